// File: rtl/sap2_pkg.sv
// Shared SAP-II W-bus definitions: source indices, default bus geometry
// and a helper for sizing source-index registers.
package sap2_pkg;

    localparam int SRC_PC  = 0;
    localparam int SRC_ACC = 1;
    localparam int SRC_MDR = 2;
    localparam int SRC_TMP = 3;
    localparam int SRC_B   = 4;
    localparam int SRC_C   = 5;
    localparam int SRC_ALU = 6;
    localparam int SRC_P1  = 7;
    localparam int SRC_P2  = 8;

    localparam int N_SRC_DEF    = 9;
    localparam int WIDTH_DEF    = 16;
    localparam int NARROW_W_DEF = 8;

    localparam logic [N_SRC_DEF-1:0] WIDE_MASK_DEF = 9'b0_0000_0001;

    // Index registers keep at least one bit so a single-source bus still elaborates.
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/wbus_rr_pick.sv
// Rotating-priority one-hot picker: the search begins just above ptr and
// wraps, so the first requester after ptr wins.
module wbus_rr_pick
    import sap2_pkg::*;
#(
    parameter int N     = N_SRC_DEF,
    parameter int PTR_W = ptr_width(N)
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [PTR_W-1:0] gnt_idx,
    output logic             any_req
);

    always_comb begin
        int   idx;
        logic found;
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = 0;
        for (int k = 1; k <= N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                gnt_idx  = PTR_W'(idx);
            end
        end
    end

    assign any_req = |req;

endmodule

// File: rtl/wbus_arbiter.sv
// W-bus source arbiter: fixed or round-robin selection, narrow-source masking,
// a bus keeper for idle cycles and a sticky contention log.
module wbus_arbiter
    import sap2_pkg::*;
#(
    parameter int               WIDTH     = WIDTH_DEF,
    parameter int               N_SRC     = N_SRC_DEF,
    parameter int               NARROW_W  = NARROW_W_DEF,
    parameter logic [N_SRC-1:0] WIDE_MASK = N_SRC'(WIDE_MASK_DEF),
    parameter int               MODE      = 0,
    parameter int               CNT_W     = 8
) (
    input  logic                   CLK,
    input  logic                   nCLR,
    input  logic [N_SRC*WIDTH-1:0] src_data,
    input  logic [N_SRC-1:0]       src_en,
    input  logic                   clr_err,
    output logic [WIDTH-1:0]       bus,
    output logic [N_SRC-1:0]       grant,
    output logic                   bus_err,
    output logic [N_SRC-1:0]       err_mask,
    output logic [CNT_W-1:0]       err_cnt
);

    localparam int               PTR_W       = ptr_width(N_SRC);
    localparam logic [PTR_W-1:0] PTR_TOP     = PTR_W'(N_SRC - 1);
    localparam logic [WIDTH-1:0] NARROW_MASK = {WIDTH{1'b1}} >> (WIDTH - NARROW_W);

    logic [WIDTH-1:0] keeper_q, keeper_d;
    logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
    logic             bus_err_q, bus_err_d;
    logic [N_SRC-1:0] err_mask_q, err_mask_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

    logic [N_SRC-1:0] pick_gnt;
    logic [PTR_W-1:0] pick_idx;
    logic             any_req;
    logic [WIDTH-1:0] sel_word;
    logic             contention;

    if (MODE == 1) begin : g_rr
        wbus_rr_pick #(.N(N_SRC), .PTR_W(PTR_W)) u_pick (
            .req     (src_en),
            .ptr     (rr_ptr_q),
            .gnt     (pick_gnt),
            .gnt_idx (pick_idx),
            .any_req (any_req)
        );
    end else begin : g_fixed
        // Bit-reversed requests searched from just above the top index give highest-index-first.
        logic [N_SRC-1:0] req_rev;
        logic [N_SRC-1:0] gnt_rev;
        logic [PTR_W-1:0] idx_rev;

        for (genvar i = 0; i < N_SRC; i++) begin : g_rev
            assign req_rev[i]  = src_en[N_SRC-1-i];
            assign pick_gnt[i] = gnt_rev[N_SRC-1-i];
        end

        wbus_rr_pick #(.N(N_SRC), .PTR_W(PTR_W)) u_pick (
            .req     (req_rev),
            .ptr     (PTR_TOP),
            .gnt     (gnt_rev),
            .gnt_idx (idx_rev),
            .any_req (any_req)
        );

        assign pick_idx = PTR_TOP - idx_rev;
    end

    always_comb begin
        sel_word = src_data[int'(pick_idx)*WIDTH +: WIDTH];
        if (!WIDE_MASK[pick_idx]) begin
            sel_word = sel_word & NARROW_MASK;
        end
        bus = any_req ? sel_word : keeper_q;
    end

    assign grant      = pick_gnt;
    assign contention = ($countones(src_en) >= 2);

    // A clear coinciding with contention restarts the log with this cycle's event.
    always_comb begin
        keeper_d   = any_req ? bus : keeper_q;
        rr_ptr_d   = any_req ? pick_idx : rr_ptr_q;
        bus_err_d  = bus_err_q;
        err_mask_d = err_mask_q;
        err_cnt_d  = err_cnt_q;
        if (contention) begin
            bus_err_d = 1'b1;
            if (clr_err) begin
                err_cnt_d  = CNT_W'(1);
                err_mask_d = src_en;
            end else begin
                if (!bus_err_q) begin
                    err_mask_d = src_en;
                end
                if (!(&err_cnt_q)) begin
                    err_cnt_d = err_cnt_q + CNT_W'(1);
                end
            end
        end else if (clr_err) begin
            bus_err_d  = 1'b0;
            err_mask_d = '0;
            err_cnt_d  = '0;
        end
    end

    always_ff @(posedge CLK or negedge nCLR) begin
        if (!nCLR) begin
            keeper_q   <= '0;
            rr_ptr_q   <= PTR_TOP;
            bus_err_q  <= 1'b0;
            err_mask_q <= '0;
            err_cnt_q  <= '0;
        end else begin
            keeper_q   <= keeper_d;
            rr_ptr_q   <= rr_ptr_d;
            bus_err_q  <= bus_err_d;
            err_mask_q <= err_mask_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign bus_err  = bus_err_q;
    assign err_mask = err_mask_q;
    assign err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_wbus_arbiter.sv
// Bench for wbus_arbiter: a fixed-priority and a round-robin instance share
// stimulus and are checked every cycle against a behavioural model.
module tb_wbus_arbiter;
    import sap2_pkg::*;

    localparam int W  = 16;
    localparam int N  = 9;
    localparam int CW = 8;

    logic           clk  = 1'b0;
    logic           nclr = 1'b0;
    logic [N*W-1:0] src_data = '0;
    logic [N-1:0]   src_en   = '0;
    logic           clr_err  = 1'b0;

    logic [W-1:0]  bus_f, bus_r;
    logic [N-1:0]  grant_f, grant_r;
    logic          err_f, err_r;
    logic [N-1:0]  mask_f, mask_r;
    logic [CW-1:0] cnt_f, cnt_r;

    int tests = 0;
    int fails = 0;

    // Behavioural model state
    logic [W-1:0] m_keep_f = '0;
    logic [W-1:0] m_keep_r = '0;
    int           m_ptr    = N - 1;
    logic         m_err    = 1'b0;
    logic [N-1:0] m_mask   = '0;
    int           m_cnt    = 0;
    int           mw_f, mw_r;

    wbus_arbiter #(.MODE(0), .CNT_W(CW)) dut_fixed (
        .CLK(clk), .nCLR(nclr), .src_data(src_data), .src_en(src_en), .clr_err(clr_err),
        .bus(bus_f), .grant(grant_f), .bus_err(err_f), .err_mask(mask_f), .err_cnt(cnt_f)
    );

    wbus_arbiter #(.MODE(1), .CNT_W(CW)) dut_rr (
        .CLK(clk), .nCLR(nclr), .src_data(src_data), .src_en(src_en), .clr_err(clr_err),
        .bus(bus_r), .grant(grant_r), .bus_err(err_r), .err_mask(mask_r), .err_cnt(cnt_r)
    );

    always #5 clk = ~clk;

    function automatic int win_fixed(input logic [N-1:0] en);
        for (int i = N - 1; i >= 0; i--) if (en[i]) return i;
        return -1;
    endfunction

    function automatic int win_rr(input logic [N-1:0] en, input int ptr);
        for (int k = 1; k <= N; k++) if (en[(ptr + k) % N]) return (ptr + k) % N;
        return -1;
    endfunction

    function automatic int popcount(input logic [N-1:0] en);
        int c = 0;
        for (int i = 0; i < N; i++) c += int'(en[i]);
        return c;
    endfunction

    // Only the PC drives a full word; every other source shows its low byte.
    function automatic logic [W-1:0] exp_bus(input int win, input logic [W-1:0] keep);
        logic [W-1:0] v;
        if (win < 0) return keep;
        v = src_data[win*W +: W];
        if (win != SRC_PC) v = v & 16'h00FF;
        return v;
    endfunction

    function automatic logic [N-1:0] onehot(input int win);
        logic [N-1:0] g = '0;
        if (win >= 0) g[win] = 1'b1;
        return g;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic [N-1:0] en, input logic clr);
        @(posedge clk);
        #2;
        src_en  = en;
        clr_err = clr;
        @(negedge clk);
        #1;
    endtask

    task automatic set_word(input int idx, input logic [W-1:0] v);
        src_data[idx*W +: W] = v;
    endtask

    always @(posedge clk or negedge nclr) begin
        if (!nclr) begin
            m_keep_f = '0;
            m_keep_r = '0;
            m_ptr    = N - 1;
            m_err    = 1'b0;
            m_mask   = '0;
            m_cnt    = 0;
        end else begin
            mw_f = win_fixed(src_en);
            mw_r = win_rr(src_en, m_ptr);
            if (src_en != '0) begin
                m_keep_f = exp_bus(mw_f, m_keep_f);
                m_keep_r = exp_bus(mw_r, m_keep_r);
                m_ptr    = mw_r;
            end
            if (popcount(src_en) >= 2) begin
                if (clr_err) begin
                    m_cnt  = 1;
                    m_mask = src_en;
                end else begin
                    if (!m_err) m_mask = src_en;
                    if (m_cnt < (1 << CW) - 1) m_cnt = m_cnt + 1;
                end
                m_err = 1'b1;
            end else if (clr_err) begin
                m_err  = 1'b0;
                m_mask = '0;
                m_cnt  = 0;
            end
        end
    end

    always @(negedge clk) begin
        checkOutput("fixed_bus",   32'(bus_f),   32'(exp_bus(win_fixed(src_en), m_keep_f)));
        checkOutput("fixed_grant", 32'(grant_f), 32'(onehot(win_fixed(src_en))));
        checkOutput("rr_bus",      32'(bus_r),   32'(exp_bus(win_rr(src_en, m_ptr), m_keep_r)));
        checkOutput("rr_grant",    32'(grant_r), 32'(onehot(win_rr(src_en, m_ptr))));
        checkOutput("fixed_err",   32'(err_f),   32'(m_err));
        checkOutput("rr_err",      32'(err_r),   32'(m_err));
        checkOutput("fixed_mask",  32'(mask_f),  32'(m_mask));
        checkOutput("rr_mask",     32'(mask_r),  32'(m_mask));
        checkOutput("fixed_cnt",   32'(cnt_f),   32'(m_cnt));
        checkOutput("rr_cnt",      32'(cnt_r),   32'(m_cnt));
    end

    initial begin
        logic [N-1:0] en;
        set_word(SRC_PC,  16'hABCD);
        set_word(SRC_ACC, 16'h12F3);
        set_word(SRC_MDR, 16'h3344);
        set_word(SRC_TMP, 16'h4455);
        set_word(SRC_B,   16'h5566);
        set_word(SRC_C,   16'h6677);
        set_word(SRC_ALU, 16'h7788);
        set_word(SRC_P1,  16'h8899);
        set_word(SRC_P2,  16'hBE77);

        // Reset state
        @(negedge clk);
        #1;
        checkOutput("rst_bus",   32'(bus_f),   32'h0000);
        checkOutput("rst_grant", 32'(grant_f), 32'h000);
        checkOutput("rst_err",   32'(err_f),   32'h0);
        checkOutput("rst_cnt",   32'(cnt_f),   32'h00);
        checkOutput("rst_rr_bus", 32'(bus_r),  32'h0000);
        #1 nclr = 1'b1;

        // Wide and narrow sources, then keeper hold
        applyStimulus(9'h001, 1'b0);
        checkOutput("pc_bus",    32'(bus_f),   32'hABCD);
        checkOutput("pc_rr_bus", 32'(bus_r),   32'hABCD);
        applyStimulus(9'h002, 1'b0);
        checkOutput("acc_bus",   32'(bus_f),   32'h00F3);
        applyStimulus(9'h000, 1'b0);
        checkOutput("keep_bus",  32'(bus_f),   32'h00F3);
        checkOutput("keep_grant", 32'(grant_f), 32'h000);
        checkOutput("keep_rr_bus", 32'(bus_r), 32'h00F3);

        // Fixed-priority contention and first-event logging
        applyStimulus(9'h101, 1'b0);
        checkOutput("p2_grant",  32'(grant_f), 32'h100);
        checkOutput("p2_bus",    32'(bus_f),   32'h0077);
        applyStimulus(9'h006, 1'b0);
        checkOutput("c1_err",    32'(err_f),   32'h1);
        checkOutput("c1_mask",   32'(mask_f),  32'h101);
        checkOutput("c1_cnt",    32'(cnt_f),   32'h01);
        checkOutput("mdr_grant", 32'(grant_f), 32'h004);
        applyStimulus(9'h000, 1'b0);
        checkOutput("c2_mask",   32'(mask_f),  32'h101);
        checkOutput("c2_cnt",    32'(cnt_f),   32'h02);
        checkOutput("c2_bus",    32'(bus_f),   32'h0044);

        // Asynchronous reset between edges
        #1 nclr = 1'b0;
        #1;
        checkOutput("arst_bus",  32'(bus_f),  32'h0000);
        checkOutput("arst_err",  32'(err_f),  32'h0);
        checkOutput("arst_mask", 32'(mask_f), 32'h000);
        checkOutput("arst_cnt",  32'(cnt_f),  32'h00);
        checkOutput("arst_rr_bus", 32'(bus_r), 32'h0000);
        #1 nclr = 1'b1;

        // Round-robin rotation from reset
        applyStimulus(9'h007, 1'b0);
        checkOutput("rr_g1", 32'(grant_r), 32'h001);
        checkOutput("fx_g1", 32'(grant_f), 32'h004);
        applyStimulus(9'h007, 1'b0);
        checkOutput("rr_g2", 32'(grant_r), 32'h002);
        applyStimulus(9'h007, 1'b0);
        checkOutput("rr_g3", 32'(grant_r), 32'h004);
        applyStimulus(9'h007, 1'b0);
        checkOutput("rr_g4", 32'(grant_r), 32'h001);
        applyStimulus(9'h000, 1'b0);
        checkOutput("rr_cnt4",  32'(cnt_r),  32'h04);
        checkOutput("rr_mask4", 32'(mask_r), 32'h007);

        // Saturation, clear alone, clear with contention
        repeat (300) applyStimulus(9'h003, 1'b0);
        applyStimulus(9'h000, 1'b0);
        checkOutput("sat_cnt", 32'(cnt_f), 32'hFF);
        checkOutput("sat_err", 32'(err_f), 32'h1);
        applyStimulus(9'h000, 1'b1);
        applyStimulus(9'h000, 1'b0);
        checkOutput("clr_cnt",  32'(cnt_f),  32'h00);
        checkOutput("clr_err",  32'(err_f),  32'h0);
        checkOutput("clr_mask", 32'(mask_f), 32'h000);
        applyStimulus(9'h030, 1'b1);
        applyStimulus(9'h000, 1'b0);
        checkOutput("clrc_cnt",  32'(cnt_f),  32'h01);
        checkOutput("clrc_err",  32'(err_f),  32'h1);
        checkOutput("clrc_mask", 32'(mask_f), 32'h030);

        // Randomised traffic with occasional data changes and reset pulses
        for (int n = 0; n < 500; n++) begin
            case ($urandom_range(0, 3))
                0: en = '0;
                1: en = onehot(int'($urandom_range(0, N - 1)));
                2: en = onehot(int'($urandom_range(0, N - 1))) | onehot(int'($urandom_range(0, N - 1)));
                default: en = N'($urandom);
            endcase
            if ($urandom_range(0, 3) == 0) set_word(int'($urandom_range(0, N - 1)), W'($urandom));
            applyStimulus(en, ($urandom_range(0, 15) == 0));
            if ($urandom_range(0, 49) == 0) begin
                #1 nclr = 1'b0;
                #1 nclr = 1'b1;
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
